crd_seg_builder: RTL

//  Downstream neighbour of crddrop. Consumes one compressed coordinate stream (17-bit sparse tokens)
//  and splits it into the two CSR write arrays: the coordinate array (crd_out) and the cumulative

---
 rtl/crd_seg_builder.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/crd_seg_builder.sv
// Splits a compressed coordinate stream into the CSR coordinate array and the cumulative
// segment array, each behind a single-entry output register with valid/ready handshake.
module crd_seg_builder #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic              flush,
  input  logic              tile_en,
  input  logic [DATA_W:0]   crd_in,
  input  logic              crd_in_valid,
  output logic              crd_in_ready,
  output logic [DATA_W:0]   crd_out,
  output logic              crd_out_valid,
  input  logic              crd_out_ready,
  output logic [DATA_W:0]   seg_out,
  output logic              seg_out_valid,
  input  logic              seg_out_ready,
  output logic              cnt_overflow
);

  // state     | meaning
  // ST_START  | waiting for a free seg slot to emit the leading 0 of a tile
  // ST_STREAM | routing coords to crd_out and running counts to seg_out
  // ST_DRAIN  | done pushed; waiting for both slots to empty before next tile
  typedef enum logic [1:0] {ST_START, ST_STREAM, ST_DRAIN} state_t;

  localparam logic [DATA_W:0] DONE_TOK = {1'b1, {(DATA_W-9){1'b0}}, 9'h100};

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  count, count_nxt;
  logic              ovf_nxt;
  logic              crd_v, seg_v;
  logic              push_crd, push_seg;
  logic [DATA_W:0]   crd_din, seg_din;
  logic              en, crd_free, seg_free;
  logic              is_ctrl, is_stop, is_done, head_ok;

  assign en       = clk_en & tile_en;
  assign crd_free = ~crd_v | crd_out_ready;
  assign seg_free = ~seg_v | seg_out_ready;
  assign is_ctrl  = crd_in[DATA_W];
  assign is_stop  = is_ctrl & (crd_in[DATA_W-1:8] == '0);
  assign is_done  = (crd_in == DONE_TOK);

  assign crd_out_valid = crd_v & tile_en;
  assign seg_out_valid = seg_v & tile_en;

  always_comb begin
    if (!is_ctrl)     head_ok = crd_free;
    else if (is_stop) head_ok = seg_free;
    else if (is_done) head_ok = crd_free & seg_free;
    else              head_ok = 1'b1;
  end

  always_comb begin
    state_nxt    = state;
    count_nxt    = count;
    ovf_nxt      = cnt_overflow;
    push_crd     = 1'b0;
    push_seg     = 1'b0;
    crd_din      = '0;
    seg_din      = '0;
    crd_in_ready = 1'b0;
    case (state)
      ST_START: begin
        if (seg_free) begin
          push_seg  = 1'b1;
          state_nxt = ST_STREAM;
        end
      end
      ST_STREAM: begin
        // Ready is withheld whenever this edge cannot commit, so no token is lost.
        crd_in_ready = head_ok & en & ~flush;
        if (crd_in_ready && crd_in_valid) begin
          if (!is_ctrl) begin
            push_crd  = 1'b1;
            crd_din   = crd_in;
            count_nxt = count + CNT_W'(1);
            if (count == '1) ovf_nxt = 1'b1;
          end else if (is_stop) begin
            push_seg = 1'b1;
            seg_din  = {{(DATA_W+1-CNT_W){1'b0}}, count};
          end else if (is_done) begin
            push_crd  = 1'b1;
            push_seg  = 1'b1;
            crd_din   = DONE_TOK;
            seg_din   = DONE_TOK;
            state_nxt = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (crd_free && seg_free) begin
          count_nxt = '0;
          ovf_nxt   = 1'b0;
          state_nxt = ST_START;
        end
      end
      default: state_nxt = ST_START;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_START;
      count        <= '0;
      cnt_overflow <= 1'b0;
      crd_out      <= '0;
      seg_out      <= '0;
      crd_v        <= 1'b0;
      seg_v        <= 1'b0;
    end else if (flush) begin
      state        <= ST_START;
      count        <= '0;
      cnt_overflow <= 1'b0;
      crd_out      <= '0;
      seg_out      <= '0;
      crd_v        <= 1'b0;
      seg_v        <= 1'b0;
    end else if (en) begin
      state        <= state_nxt;
      count        <= count_nxt;
      cnt_overflow <= ovf_nxt;
      if (push_crd) begin
        crd_out <= crd_din;
        crd_v   <= 1'b1;
      end else if (crd_out_ready) begin
        crd_v <= 1'b0;
      end
      if (push_seg) begin
        seg_out <= seg_din;
        seg_v   <= 1'b1;
      end else if (seg_out_ready) begin
        seg_v <= 1'b0;
      end
    end
  end

endmodule
